// File: rtl/serial_adder_if.sv
// Handshake and result bundle for the bit-serial adder.
// The requester (master) drives start and the operands.
// The adder (slave) returns busy, done and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first.
// Operation sequence:
//   - An accepted start loads the operand shift registers and the carry.
//   - WIDTH RUN cycles follow, one bit each.
//   - The finished word and its carry-out are copied to sum/cout in one step.
// Because of that single copy, partial results never show on the outputs.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  // One spare bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c_next;
  logic             w_last;
  logic [WIDTH-1:0] w_s_msb;
  logic [WIDTH-1:0] w_res_shift;

  // Full adder on the current LSBs of the operand shift registers.
  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c_next = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));

  // The new sum bit enters at the MSB.
  // After WIDTH shifts, bit 0 of the sum has reached position 0.
  // The shift form below also works for WIDTH=1.
  assign w_s_msb     = WIDTH'(w_s) << (WIDTH - 1);
  assign w_res_shift = (r_res >> 1) | w_s_msb;

  // True on the cycle that processes bit WIDTH-1.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Control FSM with its datapath.
  // busy, done, sum and cout are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // done is a single-cycle strobe, set only on the completing edge.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_c     <= bus.cin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          // start is deliberately not looked at while RUN is active.
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c_next;
          r_res <= w_res_shift;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_res_shift;
            r_cout  <= w_c_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder.
// Main instance uses WIDTH=8; a second instance checks the WIDTH=1 case.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  serial_adder_if #(.WIDTH(1)) bus1 ();
  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_done = 0;
  int         done_cyc[$];
  res_t       sb[$];
  res_t       e_mon;
  logic [7:0] prev_sum;
  logic       prev_cout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    t = 9'(a) + 9'(b) + 9'(c);
    return {t[7:0], t[8]};
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        $display("result: sum=0x%02h cout=%0d (expected sum=0x%02h cout=%0d)",
                 bus.sum, bus.cout, e_mon.sum, e_mon.cout);
        check("sum", 32'(bus.sum), 32'(e_mon.sum));
        check("cout", 32'(bus.cout), 32'(e_mon.cout));
      end
    end
  end

  // Bounded wait for a done pulse, starting at the current negedge.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One complete operation.
  // The operands are scrambled after acceptance.
  // While RUN is active, the old result must stay on sum/cout.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] xs, input logic xc);
    int n_busy;
    bit seen;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.cin = c;
    bus.start = 1'b1;
    sb.push_back({xs, xc});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.cin = 1'($urandom);
    n_busy = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) n_busy++;
      check("sum_hold", 32'(bus.sum), 32'(prev_sum));
      check("cout_hold", 32'(bus.cout), 32'(prev_cout));
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_cycles", 32'(n_busy), 32'(W));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("done_width", 32'(bus.done), 32'd0);
    check("sum_stable", 32'(bus.sum), 32'(xs));
    check("cout_stable", 32'(bus.cout), 32'(xc));
    prev_sum = xs;
    prev_cout = xc;
  endtask

  vec_t       vecs[10];
  res_t       e;
  logic [7:0] ta;
  logic [7:0] tb_b;
  logic [1:0] t1;
  int         nd0;
  int         dstart;
  bit         seen;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
    vecs[3] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};
    vecs[8] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};
    vecs[9] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.cin = 1'b0;
    prev_sum = 8'h00;
    prev_cout = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);

    // Releasing reset alone must not start anything.
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);

    // Table-driven operations.
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

    // A start during RUN is ignored.
    nd0 = n_done;
    @(negedge clk);
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    sb.push_back({8'h30, 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.a = 8'h33;
    bus.b = 8'h44;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    wait_done(seen);
    check("ign_done_seen", 32'(seen), 32'd1);
    repeat (12) @(negedge clk);
    check("ign_single_done", 32'(n_done - nd0), 32'd1);
    check("ign_busy", 32'(bus.busy), 32'd0);
    check("ign_sum_kept", 32'(bus.sum), 32'h30);
    prev_sum = 8'h30;
    prev_cout = 1'b0;

    // Reset in the middle of RUN clears everything at once, with no done pulse.
    @(negedge clk);
    bus.a = 8'h55;
    bus.b = 8'h66;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    nd0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_cout", 32'(bus.cout), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_rst_no_done", 32'(n_done - nd0), 32'd0);
    check("mid_rst_idle", 32'(bus.busy), 32'd0);
    prev_sum = 8'h00;
    prev_cout = 1'b0;
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // Back-to-back: start is held high through DONE.
    // Bit 0 of a, bit 0 of b and cin step through all 8 full-adder cases.
    dstart = done_cyc.size();
    @(negedge clk);
    ta = 8'($urandom);
    ta[0] = 1'b0;
    tb_b = 8'($urandom);
    tb_b[0] = 1'b0;
    bus.a = ta;
    bus.b = tb_b;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    sb.push_back(model(ta, tb_b, 1'b0));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        ta = 8'($urandom);
        ta[0] = i[2];
        tb_b = 8'($urandom);
        tb_b[0] = i[1];
        bus.a = ta;
        bus.b = tb_b;
        bus.cin = i[0];
        sb.push_back(model(ta, tb_b, i[0]));
      end else begin
        bus.start = 1'b0;
      end
      wait_done(seen);
      check("b2b_done_seen", 32'(seen), 32'd1);
    end
    @(negedge clk);
    check("b2b_done_count", 32'(done_cyc.size() - dstart), 32'd8);
    if (done_cyc.size() - dstart == 8) begin
      for (int k = 0; k < 7; k++)
        check("b2b_spacing", 32'(done_cyc[dstart+k+1] - done_cyc[dstart+k]), 32'd9);
    end
    e = model(ta, tb_b, 1'b1);
    prev_sum = e.sum;
    prev_cout = e.cout;
    check("b2b_last_sum", 32'(bus.sum), 32'(e.sum));

    // WIDTH=1 finishes in a single RUN cycle; all 8 input cases.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus1.a = i[2];
      bus1.b = i[1];
      bus1.cin = i[0];
      bus1.start = 1'b1;
      t1 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1_busy", 32'(bus1.busy), 32'd1);
      check("w1_done_early", 32'(bus1.done), 32'd0);
      @(negedge clk);
      $display("w1 op: a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", i[2], i[1], i[0], bus1.sum, bus1.cout);
      check("w1_done", 32'(bus1.done), 32'd1);
      check("w1_busy_end", 32'(bus1.busy), 32'd0);
      check("w1_sum", 32'(bus1.sum), 32'(t1[0]));
      check("w1_cout", 32'(bus1.cout), 32'(t1[1]));
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1 to 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new addition; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse; high when a result has just been loaded.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the most recent addition.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE, encoded in registers.
REQ-013 In IDLE or DONE, start=1 at edge k SHALL load shift registers with a and b, load the carry register with cin, clear the bit counter, and enter RUN.
REQ-014 In DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-015 In RUN, each edge SHALL process one bit, LSB first, using full-adder equations:
- s = a0 ^ b0 ^ c
- c_next = (a0 & b0) | (c & (a0 ^ b0))
- shift s into the MSB of an internal result register
- shift the operand registers right by one
- increment the counter.
REQ-016 At the edge processing bit WIDTH-1 (edge k+WIDTH), the block SHALL:
- copy the final result register to sum
- copy c_next to cout
- enter DONE.
REQ-017 Latency: done SHALL be high exactly during the cycle after edge k+WIDTH, for one cycle only.
REQ-018 busy SHALL be high from edge k through edge k+WIDTH, and low otherwise.
REQ-019 sum and cout SHALL hold their previous values throughout RUN; intermediate bits SHALL never appear on them.
REQ-020 sum and cout SHALL remain stable after DONE until the next completion or reset.
REQ-021 start asserted during RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-022 Changes on a, b or cin after the accepted start edge SHALL NOT affect the result.
REQ-023 A start accepted in DONE (back-to-back) SHALL begin a new operation; done still pulses exactly one cycle for the previous result.
REQ-024 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.
REQ-025 For WIDTH=1, the block SHALL complete in one RUN cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, and all internal registers to 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first accepted start after rst_n returns high SHALL operate normally.
REQ-028 Deassertion of rst_n SHALL NOT by itself start an operation.

Verification (WIDTH=8)
REQ-029 a=0x00, b=0x00, cin=0, start at edge k -> busy high edges k..k+8, done high one cycle after edge k+8, sum=0x00, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; cin=1 with the same operands -> sum=0x01, cout=1.
REQ-031 a=0x0F, b=0x01, cin=1 -> sum=0x11, cout=0; sum shows the prior result (0x01) throughout RUN.
REQ-032 start pulsed with a=0x33, b=0x44 at cycle 3 of RUN (a=0x10, b=0x20, cin=0) -> ignored; result sum=0x30, cout=0, one done pulse.
REQ-033 rst_n=0 at cycle 4 of RUN -> all outputs 0 at once, no done pulse; next op a=0x80, b=0x80 -> sum=0x00, cout=1.
REQ-034 Back-to-back: start held high through DONE -> second op accepted; two done pulses exactly 9 cycles apart; all 8 full-adder truth-table combinations exercised on bit 0.
